iccm_arbiter: RTL and testbench

Shares the single-port ICCM (instruction memory) between two requesters:
- the UART/JTAG program loader's write stream (one-cycle write pulses, no backpressure);
- the TL-UL SRAM adapter's read requests (instruction fetch / debug reads).
Loader writes are buffered in a small FIFO and drained into idle memory cycles. A priority FSM resolves starvation, read-after-write hazards and end-of-load flushing. Sits between the ICCM loader, the ICCM's TL-UL SRAM adapter and the instruction memory macro.

---
 rtl/iccm_arbiter.sv | 149 ++++++++++++++
 tb/tb_iccm_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iccm_arbiter.sv
// iccm_arbiter: shares the single-port ICCM between buffered loader writes and adapter reads; ICCM_ARB_STATS_EN adds stall/write counters
module iccm_arbiter #(
  parameter int AW           = 12,
  parameter int DW           = 32,
  parameter int WBUF_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_we_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  input  logic          ld_done_i,
  output logic          ld_full_o,
  output logic          ld_overflow_o,
  output logic          flush_done_o,
  input  logic          bus_req_i,
  input  logic [AW-1:0] bus_addr_i,
  output logic          bus_gnt_o,
  output logic [DW-1:0] bus_rdata_o,
  output logic          bus_rvalid_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  input  logic          mem_rvalid_i,
  output logic [15:0]   stall_cnt_o,
  output logic [15:0]   wr_cnt_o
);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = $clog2(WBUF_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {BUS_PRI, WR_PRI, FLUSH} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q [WBUF_DEPTH];
  logic [DW-1:0] data_q [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] vld_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] starve_q, starve_d;
  logic rd_pend_q, ovf_q;
  logic empty, full, push, hazard, rd_go, wr_go, done_pulse;

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(WBUF_DEPTH);
  // a full FIFO still accepts a push when the head retires in the same cycle
  assign push  = ld_we_i & (~full | wr_go);

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++)
      hazard = hazard | (vld_q[i] & (addr_q[i] == bus_addr_i));
    hazard = hazard & bus_req_i;
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = '0;
    rd_go      = 1'b0;
    wr_go      = 1'b0;
    done_pulse = 1'b0;
    if (!reset) begin
      case (state_q)
        BUS_PRI: begin
          rd_go    = bus_req_i & ~hazard;
          wr_go    = ~rd_go & ~empty;
          starve_d = (rd_go & ~empty) ? starve_q + 1'b1 : '0;
          state_d  = (starve_d == SW'(STARVE_LIMIT)) ? WR_PRI : BUS_PRI;
        end
        WR_PRI: begin
          wr_go   = ~empty;
          state_d = BUS_PRI;
        end
        FLUSH: begin
          wr_go      = ~empty;
          done_pulse = empty & ~ld_we_i;
          state_d    = done_pulse ? BUS_PRI : FLUSH;
        end
        default: state_d = BUS_PRI;
      endcase
      if (ld_done_i && state_q != FLUSH) state_d = FLUSH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= BUS_PRI;
      starve_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      vld_q     <= '0;
      rd_pend_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      rd_pend_q <= rd_go;
      cnt_q     <= cnt_q + CW'(push) - CW'(wr_go);
      if (ld_we_i && !push) ovf_q <= 1'b1;
      if (wr_go) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[wr_ptr_q] <= ld_addr_i;
      data_q[wr_ptr_q] <= ld_wdata_i;
    end
  end

  assign mem_req_o     = rd_go | wr_go;
  assign mem_we_o      = wr_go;
  assign mem_addr_o    = wr_go ? addr_q[rd_ptr_q] : rd_go ? bus_addr_i : '0;
  assign mem_wdata_o   = wr_go ? data_q[rd_ptr_q] : '0;
  assign bus_gnt_o     = rd_go;
  // a response landing during reset belongs to a discarded read
  assign bus_rvalid_o  = mem_rvalid_i & rd_pend_q & ~reset;
  assign bus_rdata_o   = bus_rvalid_o ? mem_rdata_i : '0;
  assign ld_full_o     = full;
  assign ld_overflow_o = ovf_q;
  assign flush_done_o  = done_pulse;

`ifdef ICCM_ARB_STATS_EN
  logic [15:0] stall_q, wrc_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      wrc_q   <= '0;
    end else begin
      if (bus_req_i && !rd_go && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
      if (wr_go && wrc_q != 16'hFFFF) wrc_q <= wrc_q + 1'b1;
    end
  end
  assign stall_cnt_o = stall_q;
  assign wr_cnt_o    = wrc_q;
`else
  assign stall_cnt_o = '0;
  assign wr_cnt_o    = '0;
`endif
endmodule

// File: tb/tb_iccm_arbiter.sv
// tb_iccm_arbiter: table vectors, corner sequences and random traffic checked against a queue-based model
module tb_iccm_arbiter;
  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int M_NORMAL = 0, M_FORCE = 1, M_FLUSH = 2;

  logic clock = 1'b0, reset = 1'b1;
  logic ld_we_i = 0, ld_done_i = 0, bus_req_i = 0, mem_rvalid_i = 0;
  logic [11:0] ld_addr_i = 0, bus_addr_i = 0;
  logic [31:0] ld_wdata_i = 0, mem_rdata_i = 0;
  logic ld_full_o, ld_overflow_o, flush_done_o, bus_gnt_o, bus_rvalid_o;
  logic mem_req_o, mem_we_o;
  logic [11:0] mem_addr_o;
  logic [31:0] bus_rdata_o, mem_wdata_o;
  logic [15:0] stall_cnt_o, wr_cnt_o;

  iccm_arbiter #(.AW(12), .DW(32), .WBUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset), .ld_we_i(ld_we_i), .ld_addr_i(ld_addr_i),
    .ld_wdata_i(ld_wdata_i), .ld_done_i(ld_done_i), .ld_full_o(ld_full_o),
    .ld_overflow_o(ld_overflow_o), .flush_done_o(flush_done_o), .bus_req_i(bus_req_i),
    .bus_addr_i(bus_addr_i), .bus_gnt_o(bus_gnt_o), .bus_rdata_o(bus_rdata_o),
    .bus_rvalid_o(bus_rvalid_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_rvalid_i(mem_rvalid_i), .stall_cnt_o(stall_cnt_o), .wr_cnt_o(wr_cnt_o));

  always #5 clock = ~clock;

  typedef struct { logic [11:0] a; logic [31:0] d; } ent_t;
  typedef struct {
    logic we; logic [11:0] wa; logic [31:0] wd; logic done; logic req; logic [11:0] ba;
    logic x_gnt; logic x_mwe; logic [11:0] x_maddr; logic x_fd; logic x_full;
  } vec_t;

  int n_chk = 0, n_bad = 0;
  logic [31:0] mm [4096];
  logic [31:0] rm [4096];
  ent_t q[$];
  int mode = M_NORMAL, starve = 0;
  bit m_ovf = 0, pend = 0;
  logic [31:0] pend_d = 0;
  logic s_gnt, s_mreq, s_mwe, s_fd, s_full, s_ovf, s_rv;
  logic [11:0] s_maddr;
  logic [31:0] s_wd, s_rd;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(logic we, logic [11:0] wa, logic [31:0] wd, logic done, logic req, logic [11:0] ba);
    ld_we_i = we; ld_addr_i = wa; ld_wdata_i = wd; ld_done_i = done; bus_req_i = req; bus_addr_i = ba;
  endtask

  // one cycle: sample, compare with the model, answer memory, advance the model
  task automatic step();
    bit hz, eg, ew, efd, erv, rv;
    int n0, om;
    ent_t h;
    logic [31:0] rd;
    #1;
    s_gnt = bus_gnt_o; s_mreq = mem_req_o; s_mwe = mem_we_o; s_maddr = mem_addr_o;
    s_wd = mem_wdata_o; s_fd = flush_done_o; s_full = ld_full_o; s_ovf = ld_overflow_o;
    s_rv = bus_rvalid_o; s_rd = bus_rdata_o;
    n0 = q.size();
    h = n0 > 0 ? q[0] : '{12'h0, 32'h0};
    hz = 0;
    foreach (q[i]) if (bus_req_i && q[i].a == bus_addr_i) hz = 1;
    eg  = !reset && mode == M_NORMAL && bus_req_i && !hz;
    ew  = !reset && !eg && n0 > 0;
    efd = !reset && mode == M_FLUSH && n0 == 0 && !ld_we_i;
    erv = !reset && mem_rvalid_i && pend;
    chk("gnt", s_gnt, eg);
    chk("mem_req", s_mreq, eg | ew);
    chk("mem_we", s_mwe, ew);
    chk("mem_addr", s_maddr, ew ? h.a : eg ? bus_addr_i : 12'h0);
    chk("mem_wdata", s_wd, ew ? h.d : 32'h0);
    chk("flush_done", s_fd, efd);
    chk("rvalid", s_rv, erv);
    chk("rdata", s_rd, erv ? pend_d : 32'h0);
    if (!reset) begin
      chk("full", s_full, n0 == DEPTH);
      chk("overflow", s_ovf, m_ovf);
    end
    rv = s_mreq;
    rd = $urandom;
    if (s_mreq && !s_mwe) rd = mm[s_maddr];
    if (s_mreq && s_mwe) mm[s_maddr] = s_wd;
    if (reset) begin
      q.delete(); mode = M_NORMAL; starve = 0; m_ovf = 0; pend = 0;
    end else begin
      om = mode;
      pend = eg;
      pend_d = rm[bus_addr_i];
      if (ew) begin
        rm[h.a] = h.d;
        void'(q.pop_front());
      end
      if (ld_we_i) begin
        if (n0 < DEPTH || ew) q.push_back('{ld_addr_i, ld_wdata_i});
        else m_ovf = 1;
      end
      if (om == M_NORMAL) begin
        starve = (eg && n0 > 0) ? starve + 1 : 0;
        if (starve == LIMIT) mode = M_FORCE;
      end else begin
        starve = 0;
        if (om == M_FORCE || efd) mode = M_NORMAL;
      end
      if (ld_done_i && om != M_FLUSH) mode = M_FLUSH;
    end
    @(posedge clock);
    @(negedge clock);
    mem_rvalid_i = rv;
    mem_rdata_i = rd;
  endtask

  vec_t tv [14];
  bit stop;
  int n;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mm[i] = {20'hC0DE0, i[11:0]};
      rm[i] = mm[i];
    end
    tv[0]  = '{1, 12'h010, 32'hA0, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0};
    tv[1]  = '{1, 12'h011, 32'hA1, 0, 0, 12'h000, 0, 1, 12'h010, 0, 0};
    tv[2]  = '{1, 12'h012, 32'hA2, 0, 0, 12'h000, 0, 1, 12'h011, 0, 0};
    tv[3]  = '{0, 12'h000, 32'h00, 0, 0, 12'h000, 0, 1, 12'h012, 0, 0};
    tv[4]  = '{0, 12'h000, 32'h00, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0};
    tv[5]  = '{1, 12'h030, 32'hB0, 0, 1, 12'h100, 1, 0, 12'h100, 0, 0};
    tv[6]  = '{1, 12'h031, 32'hB1, 0, 1, 12'h100, 1, 0, 12'h100, 0, 0};
    tv[7]  = '{1, 12'h032, 32'hB2, 0, 1, 12'h100, 1, 0, 12'h100, 0, 0};
    tv[8]  = '{0, 12'h000, 32'h00, 1, 1, 12'h100, 1, 0, 12'h100, 0, 0};
    tv[9]  = '{0, 12'h000, 32'h00, 0, 1, 12'h100, 0, 1, 12'h030, 0, 0};
    tv[10] = '{0, 12'h000, 32'h00, 0, 1, 12'h100, 0, 1, 12'h031, 0, 0};
    tv[11] = '{0, 12'h000, 32'h00, 0, 1, 12'h100, 0, 1, 12'h032, 0, 0};
    tv[12] = '{0, 12'h000, 32'h00, 0, 1, 12'h100, 0, 0, 12'h000, 1, 0};
    tv[13] = '{0, 12'h000, 32'h00, 0, 1, 12'h100, 1, 0, 12'h100, 0, 0};
    @(negedge clock);
    step();
    step();
    reset = 0;
    foreach (tv[i]) begin
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].done, tv[i].req, tv[i].ba);
      step();
      chk($sformatf("tv%0d_gnt", i), s_gnt, tv[i].x_gnt);
      chk($sformatf("tv%0d_mwe", i), s_mwe, tv[i].x_mwe);
      chk($sformatf("tv%0d_maddr", i), s_maddr, tv[i].x_maddr);
      chk($sformatf("tv%0d_fdone", i), s_fd, tv[i].x_fd);
      chk($sformatf("tv%0d_full", i), s_full, tv[i].x_full);
    end
`ifdef ICCM_ARB_STATS_EN
    chk("tv_wr_cnt", wr_cnt_o, 6);
    chk("tv_stall_cnt", stall_cnt_o, 4);
`endif
    // starvation: one pending write under continuous reads
    drive(1, 12'h040, 32'h11, 0, 1, 12'h200);
    step();
    n = 0;
    stop = 0;
    for (int k = 0; k < 20 && !stop; k++) begin
      drive(0, 0, 0, 0, 1, 12'h200);
      step();
      if (s_gnt) n++;
      else stop = 1;
    end
    chk("starve_grants", n, LIMIT);
    chk("starve_wr", s_mwe, 1);
    chk("starve_waddr", s_maddr, 12'h040);
    step();
    chk("starve_resume", s_gnt, 1);
    // read-after-write hazard
    drive(1, 12'h020, 32'h55, 0, 1, 12'h300);
    step();
    drive(0, 0, 0, 0, 1, 12'h020);
    step();
    chk("hz_gnt", s_gnt, 0);
    chk("hz_wr", s_mwe, 1);
    chk("hz_waddr", s_maddr, 12'h020);
    step();
    chk("hz_gnt_after", s_gnt, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("hz_rvalid", s_rv, 1);
    chk("hz_rdata", s_rd, 32'h55);
    // overflow: fifth write into a full FIFO under bus load
    for (int k = 0; k < 5; k++) begin
      drive(1, 12'h050 + 12'(k), 32'hD0 + k, 0, 1, 12'h400);
      step();
      if (k == 4) chk("ovf_full", s_full, 1);
    end
    drive(0, 0, 0, 0, 1, 12'h400);
    step();
    chk("ovf_set", s_ovf, 1);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) step();
    chk("ovf_sticky", s_ovf, 1);
    drive(0, 0, 0, 0, 1, 12'h054);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("ovf_dropped", s_rd, 32'hC0DE0054);
    // reset with buffered writes and a read in flight
    drive(1, 12'h060, 32'hE0, 0, 1, 12'h500);
    step();
    drive(1, 12'h061, 32'hE1, 0, 1, 12'h500);
    step();
    drive(0, 0, 0, 0, 1, 12'h500);
    step();
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_rvalid", s_rv, 0);
    reset = 0;
    step();
    chk("rst_gnt", s_gnt, 0);
    chk("rst_mreq", s_mreq, 0);
    chk("rst_full", s_full, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_rvalid2", s_rv, 0);
    step();
    chk("rst_fifo_empty", s_mreq, 0);
`ifdef ICCM_ARB_STATS_EN
    chk("rst_wr_cnt", wr_cnt_o, 0);
`endif
    // random traffic with narrow address ranges to provoke hazards
    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 3, 12'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, 12'($urandom_range(0, 7)));
      step();
    end
    reset = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (8) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end
endmodule
